// File: rtl/board_pkg.sv
// Shared types and board geometry for the game board RAM arbiter.
// State and grant encodings are used by the arbiter top and its clear sequencer.
package board_pkg;

  localparam int BOARD_W     = 80;
  localparam int BOARD_H     = 30;
  localparam int BOARD_DEPTH = BOARD_W * BOARD_H;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_GAME = 2'd2,
    GNT_CLR  = 2'd3
  } grant_e;

endpackage

// File: rtl/clear_sequencer.sv
// Board clear sweep: address counter 0..DEPTH-1, latched fill value, end-of-sweep flag.
// The counter advances only on cycles where the arbiter grants the RAM to the clear.
module clear_sequencer
  import board_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = BOARD_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_fill,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_value,
  output logic                  o_last
);

  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [DATA_WIDTH-1:0] value_r;
  logic                  last_s;

  assign last_s  = (cnt_r == ADDR_WIDTH'(DEPTH - 1));
  assign o_addr  = cnt_r;
  assign o_value = value_r;
  assign o_last  = last_s;

  // Sweep counter and fill value; a new start always rewinds to address 0.
  always_ff @(posedge i_clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r   <= {ADDR_WIDTH{1'b0}};
      value_r <= {DATA_WIDTH{1'b0}};
    end else if (i_start) begin
      cnt_r   <= {ADDR_WIDTH{1'b0}};
      value_r <= i_fill;
    end else if (i_step) begin
      cnt_r   <= last_s ? {ADDR_WIDTH{1'b0}} : cnt_r + ADDR_WIDTH'(1);
      value_r <= value_r;
    end else begin
      cnt_r   <= cnt_r;
      value_r <= value_r;
    end
  end

endmodule

// File: rtl/board_ram_arbiter.sv
// Single-port board RAM arbiter: video reads, game read/write with anti-starvation,
// and a clear sweep that yields to video. Read return valids are registered here.
module board_ram_arbiter
  import board_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = BOARD_DEPTH,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  i_clk,
  input  logic                  rstn,
  input  logic                  i_vid_req,
  input  logic [ADDR_WIDTH-1:0] i_vid_addr,
  output logic                  o_vid_valid,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  output logic                  o_vid_miss,
  input  logic                  i_gm_req,
  input  logic                  i_gm_we,
  input  logic [ADDR_WIDTH-1:0] i_gm_addr,
  input  logic [DATA_WIDTH-1:0] i_gm_wdata,
  output logic                  o_gm_ack,
  output logic                  o_gm_rvalid,
  output logic [DATA_WIDTH-1:0] o_gm_rdata,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_clear_value,
  output logic                  o_busy,
  output logic                  o_clear_done,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_write,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e                state_r;
  grant_e                grant_s;
  logic [WAIT_W-1:0]     wait_r;
  logic                  starved_s;
  logic                  miss_s;
  logic                  ack_s;
  logic                  start_s;
  logic                  step_s;
  logic                  clr_last_s;
  logic [ADDR_WIDTH-1:0] clr_addr_s;
  logic [DATA_WIDTH-1:0] clr_value_s;
  logic [ADDR_WIDTH-1:0] addr_hold_r;
  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic                  ram_write_s;
  logic [DATA_WIDTH-1:0] ram_data_s;
  logic                  vid_valid_r;
  logic                  gm_rvalid_r;
  logic                  busy_r;
  logic                  done_r;

  assign starved_s = i_gm_req && (wait_r == WAIT_W'(MAX_WAIT));
  assign ack_s     = (grant_s == GNT_GAME);
  assign start_s   = (state_r == ST_IDLE) && i_clear;
  assign step_s    = (grant_s == GNT_CLR);

  // Per-cycle grant; the game is only served in IDLE, where starvation overrides video.
  always_comb begin
    grant_s = GNT_NONE;
    miss_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (starved_s) begin
          grant_s = GNT_GAME;
          miss_s  = i_vid_req;
        end else if (i_vid_req) begin
          grant_s = GNT_VID;
        end else if (i_gm_req) begin
          grant_s = GNT_GAME;
        end else begin
          grant_s = GNT_NONE;
        end
      end
      ST_CLEAR: begin
        if (i_vid_req) begin
          grant_s = GNT_VID;
        end else begin
          grant_s = GNT_CLR;
        end
      end
      ST_DONE: begin
        if (i_vid_req) begin
          grant_s = GNT_VID;
        end else begin
          grant_s = GNT_NONE;
        end
      end
      default: begin
        grant_s = GNT_NONE;
      end
    endcase
  end

  // RAM port mux; with no grant the address parks on its previous value.
  always_comb begin
    ram_addr_s  = addr_hold_r;
    ram_write_s = 1'b0;
    ram_data_s  = {DATA_WIDTH{1'b0}};
    case (grant_s)
      GNT_VID: begin
        ram_addr_s = i_vid_addr;
      end
      GNT_GAME: begin
        ram_addr_s  = i_gm_addr;
        ram_write_s = i_gm_we;
        ram_data_s  = i_gm_we ? i_gm_wdata : {DATA_WIDTH{1'b0}};
      end
      GNT_CLR: begin
        ram_addr_s  = clr_addr_s;
        ram_write_s = 1'b1;
        ram_data_s  = clr_value_s;
      end
      default: begin
        ram_addr_s = addr_hold_r;
      end
    endcase
  end

  // Clear FSM with registered busy/done flags.
  always_ff @(posedge i_clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_clear) begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
          done_r <= 1'b0;
        end
        ST_CLEAR: begin
          if (step_s && clr_last_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Game wait counter: counts unacked request cycles, saturating at MAX_WAIT.
  always_ff @(posedge i_clk or negedge rstn) begin
    if (!rstn) begin
      wait_r <= {WAIT_W{1'b0}};
    end else if (!i_gm_req || ack_s) begin
      wait_r <= {WAIT_W{1'b0}};
    end else if (wait_r != WAIT_W'(MAX_WAIT)) begin
      wait_r <= wait_r + WAIT_W'(1);
    end else begin
      wait_r <= wait_r;
    end
  end

  // Return-path valids and the parked RAM address.
  always_ff @(posedge i_clk or negedge rstn) begin
    if (!rstn) begin
      vid_valid_r <= 1'b0;
      gm_rvalid_r <= 1'b0;
      addr_hold_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      vid_valid_r <= (grant_s == GNT_VID);
      gm_rvalid_r <= (grant_s == GNT_GAME) && !i_gm_we;
      addr_hold_r <= ram_addr_s;
    end
  end

  clear_sequencer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_clear_seq (
    .i_clk  (i_clk),
    .rstn   (rstn),
    .i_start(start_s),
    .i_fill (i_clear_value),
    .i_step (step_s),
    .o_addr (clr_addr_s),
    .o_value(clr_value_s),
    .o_last (clr_last_s)
  );

  assign o_vid_valid  = vid_valid_r;
  assign o_vid_data   = vid_valid_r ? i_ram_data : {DATA_WIDTH{1'b0}};
  assign o_vid_miss   = miss_s;
  assign o_gm_ack     = ack_s;
  assign o_gm_rvalid  = gm_rvalid_r;
  assign o_gm_rdata   = gm_rvalid_r ? i_ram_data : {DATA_WIDTH{1'b0}};
  assign o_busy       = busy_r;
  assign o_clear_done = done_r;
  assign o_ram_addr   = ram_addr_s;
  assign o_ram_write  = ram_write_s;
  assign o_ram_data   = ram_data_s;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter with a behavioural registered-read RAM.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_board_ram_arbiter;
  localparam int AW       = 12;
  localparam int DW       = 3;
  localparam int DEPTH    = 2400;
  localparam int MAX_WAIT = 15;

  logic          i_clk = 1'b0;
  logic          rstn  = 1'b0;
  logic          i_vid_req = 1'b0;
  logic [AW-1:0] i_vid_addr = '0;
  logic          o_vid_valid;
  logic [DW-1:0] o_vid_data;
  logic          o_vid_miss;
  logic          i_gm_req = 1'b0;
  logic          i_gm_we = 1'b0;
  logic [AW-1:0] i_gm_addr = '0;
  logic [DW-1:0] i_gm_wdata = '0;
  logic          o_gm_ack;
  logic          o_gm_rvalid;
  logic [DW-1:0] o_gm_rdata;
  logic          i_clear = 1'b0;
  logic [DW-1:0] i_clear_value = '0;
  logic          o_busy;
  logic          o_clear_done;
  logic [AW-1:0] o_ram_addr;
  logic          o_ram_write;
  logic [DW-1:0] o_ram_data;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  // RAM model: synchronous write, registered read
  always @(posedge i_clk) begin
    if (o_ram_write) mem[o_ram_addr] <= o_ram_data;
    ram_q <= mem[o_ram_addr];
  end

  board_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(i_clk), .rstn(rstn),
    .i_vid_req(i_vid_req), .i_vid_addr(i_vid_addr), .o_vid_valid(o_vid_valid),
    .o_vid_data(o_vid_data), .o_vid_miss(o_vid_miss),
    .i_gm_req(i_gm_req), .i_gm_we(i_gm_we), .i_gm_addr(i_gm_addr), .i_gm_wdata(i_gm_wdata),
    .o_gm_ack(o_gm_ack), .o_gm_rvalid(o_gm_rvalid), .o_gm_rdata(o_gm_rdata),
    .i_clear(i_clear), .i_clear_value(i_clear_value), .o_busy(o_busy),
    .o_clear_done(o_clear_done), .o_ram_addr(o_ram_addr), .o_ram_write(o_ram_write),
    .o_ram_data(o_ram_data), .i_ram_data(ram_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One game transaction; checks ack, write strobe and the read return.
  task automatic gm_access(input string tag, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    bit acked = 1'b0;
    @(negedge i_clk);
    i_gm_req = 1'b1; i_gm_we = we; i_gm_addr = addr; i_gm_wdata = wd;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (o_gm_ack) begin
        acked = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    check({tag, "_ack"}, 32'(acked), 32'd1);
    check({tag, "_we"}, 32'(o_ram_write), 32'(we));
    @(negedge i_clk);
    i_gm_req = 1'b0; i_gm_we = 1'b0;
    check({tag, "_rvalid"}, 32'(o_gm_rvalid), 32'(!we));
    if (!we) check({tag, "_rdata"}, 32'(o_gm_rdata), 32'(exp_rd));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy, done_k, ack_k, misses;
    bit b, d, busy_at_done;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_vid_valid", 32'(o_vid_valid), 32'd0);
    check("rst_gm_ack", 32'(o_gm_ack), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_clear_done), 32'd0);
    check("rst_ram_addr", 32'(o_ram_addr), 32'd0);
    check("rst_ram_write", 32'(o_ram_write), 32'd0);
    rstn = 1'b1;

    // Video read of address 5 holding 1
    gm_access("wr5", 1'b1, 12'd5, 3'd1, 3'd0);
    @(negedge i_clk);
    i_vid_req = 1'b1; i_vid_addr = 12'd5;
    #1;
    check("vid_addr", 32'(o_ram_addr), 32'd5);
    check("vid_we", 32'(o_ram_write), 32'd0);
    @(negedge i_clk);
    i_vid_req = 1'b0;
    check("vid_valid", 32'(o_vid_valid), 32'd1);
    check("vid_data", 32'(o_vid_data), 32'd1);
    check("vid_we2", 32'(o_ram_write), 32'd0);
    @(negedge i_clk);
    check("vid_valid_off", 32'(o_vid_valid), 32'd0);
    check("vid_data_off", 32'(o_vid_data), 32'd0);

    // Game write then read back
    gm_access("wr100", 1'b1, 12'd100, 3'd4, 3'd0);
    gm_access("rd100", 1'b0, 12'd100, 3'd0, 3'd4);

    // Starvation: continuous video, game forced through after MAX_WAIT waits
    @(negedge i_clk);
    i_vid_req = 1'b1; i_vid_addr = 12'd9;
    i_gm_req = 1'b1; i_gm_we = 1'b0; i_gm_addr = 12'd100;
    misses = 0; ack_k = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (o_vid_miss) misses++;
      if (o_gm_ack) begin
        ack_k = k;
        break;
      end
      @(negedge i_clk);
    end
    check("starve_ack_cycle", 32'(ack_k), 32'(MAX_WAIT));
    check("starve_misses", 32'(misses), 32'd1);
    @(negedge i_clk);
    i_vid_req = 1'b0; i_gm_req = 1'b0;
    check("starve_rvalid", 32'(o_gm_rvalid), 32'd1);
    check("starve_rdata", 32'(o_gm_rdata), 32'd4);
    check("starve_vid_dropped", 32'(o_vid_valid), 32'd0);

    // Clear with value 0, no video; simultaneous game write is served first
    gm_access("pre0", 1'b1, 12'd0, 3'd5, 3'd0);
    gm_access("pre1219", 1'b1, 12'd1219, 3'd5, 3'd0);
    gm_access("pre2399", 1'b1, 12'd2399, 3'd5, 3'd0);
    @(negedge i_clk);
    i_clear = 1'b1; i_clear_value = 3'd0;
    i_gm_req = 1'b1; i_gm_we = 1'b1; i_gm_addr = 12'd3000; i_gm_wdata = 3'd7;
    #1;
    check("clr_gm_same_ack", 32'(o_gm_ack), 32'd1);
    check("clr_busy_pre", 32'(o_busy), 32'd0);
    nbusy = 0; done_k = -1; busy_at_done = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge i_clk);
      i_clear = 1'b0; i_gm_req = 1'b0; i_gm_we = 1'b0;
      if (o_busy) nbusy++;
      if (o_clear_done) begin
        done_k = k;
        busy_at_done = o_busy;
        break;
      end
    end
    check("clr_busy_cycles", 32'(nbusy), 32'(DEPTH));
    check("clr_done_cycle", 32'(done_k), 32'(DEPTH));
    check("clr_busy_at_done", 32'(busy_at_done), 32'd0);
    @(negedge i_clk);
    check("clr_done_pulse", 32'(o_clear_done), 32'd0);
    gm_access("rd0", 1'b0, 12'd0, 3'd0, 3'd0);
    gm_access("rd1219", 1'b0, 12'd1219, 3'd0, 3'd0);
    gm_access("rd2399", 1'b0, 12'd2399, 3'd0, 3'd0);
    gm_access("rd3000", 1'b0, 12'd3000, 3'd0, 3'd7);

    // Clear with value 2, video on alternate cycles and a held game read
    @(negedge i_clk);
    i_clear = 1'b1; i_clear_value = 3'd2;
    nbusy = 0; done_k = -1; ack_k = -1; misses = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge i_clk);
      i_clear = 1'b0;
      b = o_busy; d = o_clear_done;
      i_vid_req = b && (k % 2 == 0); i_vid_addr = 12'd7;
      i_gm_req = 1'b1; i_gm_we = 1'b0; i_gm_addr = 12'd50;
      #1;
      if (b) nbusy++;
      if (d) done_k = k;
      if (o_vid_miss) misses++;
      if (o_gm_ack) begin
        ack_k = k;
        break;
      end
    end
    check("clr2_busy_cycles", 32'(nbusy), 32'(2 * DEPTH));
    check("clr2_done_cycle", 32'(done_k), 32'(2 * DEPTH));
    check("clr2_ack_cycle", 32'(ack_k), 32'(2 * DEPTH + 1));
    check("clr2_misses", 32'(misses), 32'd0);
    @(negedge i_clk);
    i_gm_req = 1'b0; i_vid_req = 1'b0;
    check("clr2_rvalid", 32'(o_gm_rvalid), 32'd1);
    check("clr2_rdata", 32'(o_gm_rdata), 32'd2);

    // Reset at sweep index 1000, then restart
    @(negedge i_clk);
    i_clear = 1'b1; i_clear_value = 3'd6;
    for (int k = 0; k < 1001; k++) begin
      @(negedge i_clk);
      i_clear = 1'b0;
    end
    #1;
    check("mid_addr", 32'(o_ram_addr), 32'd1000);
    check("mid_we", 32'(o_ram_write), 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_we", 32'(o_ram_write), 32'd0);
    check("mid_rst_addr", 32'(o_ram_addr), 32'd0);
    check("mid_rst_data", 32'(o_ram_data), 32'd0);
    repeat (2) @(negedge i_clk);
    rstn = 1'b1;
    nbusy = 0; misses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      if (o_busy) nbusy++;
      if (o_clear_done) misses++;
    end
    check("post_rst_idle", 32'(nbusy), 32'd0);
    check("post_rst_no_done", 32'(misses), 32'd0);
    gm_access("rd999", 1'b0, 12'd999, 3'd0, 3'd6);
    gm_access("rd1000", 1'b0, 12'd1000, 3'd0, 3'd2);
    @(negedge i_clk);
    i_clear = 1'b1; i_clear_value = 3'd3;
    @(negedge i_clk);
    i_clear = 1'b0;
    #1;
    check("restart_busy", 32'(o_busy), 32'd1);
    check("restart_addr", 32'(o_ram_addr), 32'd0);
    check("restart_we", 32'(o_ram_write), 32'd1);
    check("restart_data", 32'(o_ram_data), 32'd3);
    done_k = -1;
    for (int k = 1; k < 3000; k++) begin
      @(negedge i_clk);
      if (o_clear_done) begin
        done_k = k;
        break;
      end
    end
    check("restart_done_cycle", 32'(done_k), 32'(DEPTH));
    gm_access("rd1000b", 1'b0, 12'd1000, 3'd0, 3'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
